// File: rtl/maxpool_pack_writer.sv
// maxpool_pack_writer: output stage of the CNN accelerator.
// Takes a raster stream of 8-bit conv pixels and applies 2x2 stride-2 max pooling.
// A half-width line buffer holds the horizontal maxima of each even row.
// Pooled pixels are packed eight per 64-bit word; pixel k sits at bits [8k+7:8k].
// Each complete word is written to DRAM at an auto-incrementing address.
// The partial last word of a frame is zero-padded. It and frame_done appear
// together in the cycle after the frame's last beat.
module maxpool_pack_writer #(
    parameter int CONV_W = 28,
    parameter int CONV_H = 28,
    parameter int AW     = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          busy,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [63:0]   wr_data,
    output logic          frame_done
);

    localparam int HALF_W = CONV_W / 2;
    localparam int COL_W  = $clog2(CONV_W);
    localparam int ROW_W  = (CONV_H > 1) ? $clog2(CONV_H) : 1;
    localparam int IDX_W  = (HALF_W > 1) ? $clog2(HALF_W) : 1;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_EVEN_ROW = 2'd1,
        S_ODD_ROW  = 2'd2,
        S_FLUSH    = 2'd3
    } state_t;

    // Larger of two unsigned pixels.
    function automatic logic [7:0] max8(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Place one pooled pixel into its byte slot of the pack word.
    function automatic logic [63:0] insert_byte(input logic [63:0] word,
                                                input logic [2:0]  slot,
                                                input logic [7:0]  pix);
        logic [63:0] res;
        res = word;
        res[{slot, 3'b000} +: 8] = pix;
        return res;
    endfunction

    state_t              r_state;
    state_t              w_next_state;
    logic                r_busy;
    logic [COL_W-1:0]    r_col;
    logic [ROW_W-1:0]    r_row;
    logic [7:0]          r_p0;
    logic [2:0]          r_pack_cnt;
    logic [63:0]         r_pack;
    logic [AW-1:0]       r_ptr;
    logic [7:0]          r_line_buf [HALF_W];
    logic [HALF_W-1:0]   r_lb_valid;
    logic                r_wr_en;
    logic [AW-1:0]       r_wr_addr;
    logic [63:0]         r_wr_data;
    logic                r_frame_done;

    logic                w_start_ok;
    logic                w_beat;
    logic                w_pair_end;
    logic                w_row_end;
    logic                w_last_row;
    logic [IDX_W-1:0]    w_idx;
    logic [7:0]          w_hmax;
    logic [7:0]          w_lb;
    logic [7:0]          w_pooled;
    logic                w_lb_wr;
    logic                w_push;
    logic                w_frame_end;
    logic                w_write;
    logic [63:0]         w_word;

    // Beat qualification and the pooling datapath for the current beat.
    always_comb begin
        w_start_ok  = (r_state == S_IDLE) && start;
        w_beat      = in_valid && ((r_state == S_EVEN_ROW) || (r_state == S_ODD_ROW));
        w_pair_end  = r_col[0];
        w_row_end   = (r_col == COL_W'(CONV_W - 1));
        w_last_row  = (r_row == ROW_W'(CONV_H - 1));
        w_idx       = IDX_W'(r_col >> 1);
        w_hmax      = max8(r_p0, in_data);
        // An entry never written this frame contributes nothing to the max.
        if (r_lb_valid[w_idx]) begin
            w_lb = r_line_buf[w_idx];
        end else begin
            w_lb = 8'h00;
        end
        w_pooled    = max8(w_lb, w_hmax);
        w_lb_wr     = w_beat && (r_state == S_EVEN_ROW) && w_pair_end;
        w_push      = w_beat && (r_state == S_ODD_ROW) && w_pair_end;
        w_frame_end = w_push && w_row_end && w_last_row;
        w_write     = w_push && ((r_pack_cnt == 3'd7) || w_frame_end);
        w_word      = insert_byte(r_pack, r_pack_cnt, w_pooled);
    end

    // Next-state logic of the row-sequencing FSM.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_EVEN_ROW;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_EVEN_ROW: begin
                if (w_beat && w_row_end) begin
                    w_next_state = S_ODD_ROW;
                end else begin
                    w_next_state = S_EVEN_ROW;
                end
            end
            S_ODD_ROW: begin
                if (w_beat && w_row_end) begin
                    if (w_last_row) begin
                        w_next_state = S_FLUSH;
                    end else begin
                        w_next_state = S_EVEN_ROW;
                    end
                end else begin
                    w_next_state = S_ODD_ROW;
                end
            end
            S_FLUSH: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State register, row/column counters and the pending pixel of a pair.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_col      <= {COL_W{1'b0}};
            r_row      <= {ROW_W{1'b0}};
            r_p0       <= 8'h00;
            r_lb_valid <= {HALF_W{1'b0}};
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            if (w_start_ok) begin
                r_col      <= {COL_W{1'b0}};
                r_row      <= {ROW_W{1'b0}};
                r_lb_valid <= {HALF_W{1'b0}};
            end
            if (w_beat) begin
                if (w_row_end) begin
                    r_col <= {COL_W{1'b0}};
                    r_row <= r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
                if (!w_pair_end) begin
                    r_p0 <= in_data;
                end
            end
            if (w_lb_wr) begin
                r_lb_valid[w_idx] <= 1'b1;
            end
        end
    end

    // Line buffer storage for even-row horizontal maxima; gated by the valid flags.
    always_ff @(posedge clk) begin
        if (w_lb_wr) begin
            r_line_buf[w_idx] <= w_hmax;
        end
    end

    // Packing of pooled pixels, the write pointer and the registered write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pack_cnt   <= 3'd0;
            r_pack       <= 64'd0;
            r_ptr        <= {AW{1'b0}};
            r_wr_en      <= 1'b0;
            r_wr_addr    <= {AW{1'b0}};
            r_wr_data    <= 64'd0;
            r_frame_done <= 1'b0;
        end else begin
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;
            if (w_start_ok) begin
                r_ptr      <= base_addr;
                r_pack_cnt <= 3'd0;
                r_pack     <= 64'd0;
            end
            if (w_push) begin
                if (w_write) begin
                    // Full word, or the zero-padded tail of the frame.
                    r_wr_en      <= 1'b1;
                    r_wr_addr    <= r_ptr;
                    r_wr_data    <= w_word;
                    r_ptr        <= r_ptr + AW'(1);
                    r_pack       <= 64'd0;
                    r_pack_cnt   <= 3'd0;
                    r_frame_done <= w_frame_end;
                end else begin
                    r_pack     <= w_word;
                    r_pack_cnt <= r_pack_cnt + 3'd1;
                end
            end
        end
    end

    assign busy       = r_busy;
    assign wr_en      = r_wr_en;
    assign wr_addr    = r_wr_addr;
    assign wr_data    = r_wr_data;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_maxpool_pack_writer.sv
// Self-checking bench for maxpool_pack_writer.
// Three instances share the pixel stream: default 28x28, 16x2 (exact word fill)
// and 4x2 (small ramp). Only the instance that was started consumes beats.
// Expected writes come from a frame-level pooling/packing model over the image.
module tb_maxpool_pack_writer;

    typedef struct {
        logic [9:0]  addr;
        logic [63:0] data;
        int          cyc;
        logic        done;
        logic        en;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic [9:0]  base_addr;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        busy_a, busy_b, busy_c;
    logic        wr_en_a, wr_en_b, wr_en_c;
    logic [9:0]  wr_addr_a, wr_addr_b, wr_addr_c;
    logic [63:0] wr_data_a, wr_data_b, wr_data_c;
    logic        frame_done_a, frame_done_b, frame_done_c;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   img [28][28];
    int   beat_cyc [28][28];
    ev_t  obs_a[$];
    ev_t  obs_b[$];
    ev_t  obs_c[$];
    ev_t  exp_q[$];
    ev_t  saved[$];

    maxpool_pack_writer dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .busy(busy_a), .wr_en(wr_en_a),
        .wr_addr(wr_addr_a), .wr_data(wr_data_a), .frame_done(frame_done_a)
    );

    maxpool_pack_writer #(.CONV_W(16), .CONV_H(2), .AW(10)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .busy(busy_b), .wr_en(wr_en_b),
        .wr_addr(wr_addr_b), .wr_data(wr_data_b), .frame_done(frame_done_b)
    );

    maxpool_pack_writer #(.CONV_W(4), .CONV_H(2), .AW(10)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .busy(busy_c), .wr_en(wr_en_c),
        .wr_addr(wr_addr_c), .wr_data(wr_data_c), .frame_done(frame_done_c)
    );

    always #5 clk = ~clk;

    // Cycle counter: number of rising edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe or frame_done pulse of each instance.
    always @(negedge clk) begin
        if (wr_en_a || frame_done_a)
            obs_a.push_back('{addr: wr_addr_a, data: wr_data_a, cyc: cyc, done: frame_done_a, en: wr_en_a});
        if (wr_en_b || frame_done_b)
            obs_b.push_back('{addr: wr_addr_b, data: wr_data_b, cyc: cyc, done: frame_done_b, en: wr_en_b});
        if (wr_en_c || frame_done_c)
            obs_c.push_back('{addr: wr_addr_c, data: wr_data_c, cyc: cyc, done: frame_done_c, en: wr_en_c});
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic busy_of(input int which);
        if (which == 0) return busy_a;
        else if (which == 1) return busy_b;
        else return busy_c;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic fill_ramp(input int w);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = (r * w + c) % 256;
    endtask

    task automatic fill_const(input int v);
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = v;
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 28; r++)
            for (int c = 0; c < 28; c++)
                img[r][c] = int'($urandom_range(0, 255));
    endtask

    task automatic do_start(input int which, input logic [9:0] base);
        base_addr = base;
        case (which)
            0: start_a = 1'b1;
            1: start_b = 1'b1;
            default: start_c = 1'b1;
        endcase
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        start_c = 1'b0;
        chk($sformatf("busy_after_start%0d", which), 64'(busy_of(which)), 64'd1);
    endtask

    // Stream a w x h frame from img; optionally stop after max_beats beats.
    task automatic drive_frame(input int w, input int h, input int gap_pct,
                               input int max_beats, input bit restart);
        int n;
        n = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                if (max_beats >= 0 && n >= max_beats) return;
                while (int'($urandom_range(0, 99)) < gap_pct) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                    @(negedge clk);
                end
                in_valid = 1'b1;
                in_data  = 8'(img[r][c]);
                beat_cyc[r][c] = cyc;
                if (restart && r == 5 && c == 0) begin
                    start_a   = 1'b1;
                    base_addr = 10'h3FF;
                end
                @(negedge clk);
                start_a = 1'b0;
                n++;
            end
        end
        in_valid = 1'b0;
    endtask

    // Frame-level model: pool 2x2 blocks in raster order, pack 8 per word.
    task automatic build_exp(input int w, input int h, input logic [9:0] base);
        int          n;
        int          p;
        logic [63:0] word;
        logic [9:0]  addr;
        logic        last;
        exp_q.delete();
        n = 0;
        word = 64'd0;
        addr = base;
        for (int pr = 0; pr < h / 2; pr++) begin
            for (int pc = 0; pc < w / 2; pc++) begin
                p = imax(imax(img[2*pr][2*pc], img[2*pr][2*pc+1]),
                         imax(img[2*pr+1][2*pc], img[2*pr+1][2*pc+1]));
                word[8*(n%8) +: 8] = 8'(p);
                n++;
                last = (pr == h / 2 - 1) && (pc == w / 2 - 1);
                if ((n % 8) == 0 || last) begin
                    exp_q.push_back('{addr: addr, data: word,
                                      cyc: beat_cyc[2*pr+1][2*pc+1] + 1,
                                      done: last, en: 1'b1});
                    addr = addr + 10'd1;
                    word = 64'd0;
                end
            end
        end
    endtask

    task automatic check_frame(input int which, input string tag);
        ev_t got[$];
        if (which == 0) got = obs_a;
        else if (which == 1) got = obs_b;
        else got = obs_c;
        chk({tag, "_nevents"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            chk($sformatf("%s_en[%0d]", tag, i), 64'(got[i].en), 64'(exp_q[i].en));
            chk($sformatf("%s_addr[%0d]", tag, i), 64'(got[i].addr), 64'(exp_q[i].addr));
            chk($sformatf("%s_data[%0d]", tag, i), got[i].data, exp_q[i].data);
            chk($sformatf("%s_cyc[%0d]", tag, i), 64'(got[i].cyc), 64'(exp_q[i].cyc));
            chk($sformatf("%s_done[%0d]", tag, i), 64'(got[i].done), 64'(exp_q[i].done));
        end
        chk({tag, "_busy_end"}, 64'(busy_of(which)), 64'd0);
    endtask

    initial begin
        int ndone;
        logic [9:0] b;
        rst = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        base_addr = 10'd0;
        in_valid = 1'b0;
        in_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_wr_en", 64'(wr_en_a), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr_a), 64'd0);
        chk("rst_wr_data", wr_data_a, 64'd0);
        chk("rst_frame_done", 64'(frame_done_a), 64'd0);
        chk("rst_busy_b", 64'(busy_b), 64'd0);
        chk("rst_busy_c", 64'(busy_c), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Small 4x2 ramp: pooled 9 and 8 in a single flush word at 5.
        fill_const(0);
        img[0][0] = 1; img[0][1] = 9; img[0][2] = 3; img[0][3] = 2;
        img[1][0] = 4; img[1][1] = 0; img[1][2] = 7; img[1][3] = 8;
        obs_c.delete();
        do_start(2, 10'd5);
        drive_frame(4, 2, 0, -1, 1'b0);
        repeat (4) @(negedge clk);
        build_exp(4, 2, 10'd5);
        check_frame(2, "small");
        if (obs_c.size() > 0) chk("small_word", obs_c[0].data, 64'h0000_0000_0000_0809);

        // Exact fill: 16x2 of 0xAA gives exactly one full word.
        fill_const(8'hAA);
        obs_b.delete();
        do_start(1, 10'd200);
        drive_frame(16, 2, 0, -1, 1'b0);
        repeat (4) @(negedge clk);
        build_exp(16, 2, 10'd200);
        check_frame(1, "exact");
        if (obs_b.size() > 0) chk("exact_word", obs_b[0].data, 64'hAAAA_AAAA_AAAA_AAAA);

        // Default ramp frame; a start pulse mid-frame must be ignored.
        fill_ramp(28);
        obs_a.delete();
        do_start(0, 10'd37);
        drive_frame(28, 28, 0, -1, 1'b1);
        repeat (4) @(negedge clk);
        build_exp(28, 28, 10'd37);
        check_frame(0, "ramp");
        if (obs_a.size() > 0)
            for (int k = 0; k < 8; k++)
                chk($sformatf("ramp_w0_b%0d", k), 64'(obs_a[0].data[8*k +: 8]), 64'(28 + 2 * k + 1));
        if (obs_a.size() > 24) chk("ramp_w24_upper", 64'(obs_a[24].data[63:32]), 64'd0);
        ndone = 0;
        foreach (obs_a[i]) if (obs_a[i].done) ndone++;
        chk("ramp_done_count", 64'(ndone), 64'd1);

        // Random image, gap-free, then the same image with ~40% idle cycles.
        fill_rand();
        b = 10'($urandom_range(0, 900));
        obs_a.delete();
        do_start(0, b);
        drive_frame(28, 28, 0, -1, 1'b0);
        repeat (4) @(negedge clk);
        build_exp(28, 28, b);
        check_frame(0, "nogap");
        saved = obs_a;
        obs_a.delete();
        do_start(0, b);
        drive_frame(28, 28, 40, -1, 1'b0);
        repeat (4) @(negedge clk);
        build_exp(28, 28, b);
        check_frame(0, "gaps");
        chk("gaps_vs_nogap_n", 64'(obs_a.size()), 64'(saved.size()));
        for (int i = 0; i < saved.size() && i < obs_a.size(); i++) begin
            chk($sformatf("gaps_same_data[%0d]", i), obs_a[i].data, saved[i].data);
            chk($sformatf("gaps_same_addr[%0d]", i), 64'(obs_a[i].addr), 64'(saved[i].addr));
        end

        // Address wrap from 1020.
        fill_rand();
        obs_a.delete();
        do_start(0, 10'd1020);
        drive_frame(28, 28, 20, -1, 1'b0);
        repeat (4) @(negedge clk);
        build_exp(28, 28, 10'd1020);
        check_frame(0, "wrap");
        if (obs_a.size() > 24) chk("wrap_last_addr", 64'(obs_a[24].addr), 64'd20);

        // Reset in the middle of the first odd row with five pooled pixels packed.
        fill_rand();
        obs_a.delete();
        do_start(0, 10'd300);
        drive_frame(28, 28, 0, 39, 1'b0);
        chk("midrst_busy_before", 64'(busy_a), 64'd1);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 64'(busy_a), 64'd0);
        chk("midrst_wr_en", 64'(wr_en_a), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr_a), 64'd0);
        chk("midrst_wr_data", wr_data_a, 64'd0);
        chk("midrst_frame_done", 64'(frame_done_a), 64'd0);
        chk("midrst_no_write", 64'(obs_a.size()), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        fill_rand();
        obs_a.delete();
        do_start(0, 10'd0);
        drive_frame(28, 28, 0, -1, 1'b0);
        repeat (4) @(negedge clk);
        build_exp(28, 28, 10'd0);
        check_frame(0, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/maxpool_pack_writer.md
Name: maxpool_pack_writer

Overview:
Output stage of the CNN accelerator, directly downstream of the convolution/ReLU datapath. Consumes a raster stream of 8-bit unsigned conv output pixels, one per beat. Performs 2x2 stride-2 max pooling using a half-width line buffer, and packs 8 pooled pixels into each 64-bit word. Issues single-cycle DRAM write commands (DRAMwriteEn/Addr/Data) with auto-incrementing addresses.

Parameters:
CONV_W, 28, conv output row width in pixels; must be even.
CONV_H, 28, conv output rows per frame (one channel); must be even.
AW, 10, DRAM address width.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse; begins a frame; samples base_addr
base_addr  in  AW  first write address of the frame
in_valid  in  1  pixel beat valid
in_data  in  8  conv pixel, unsigned (post-ReLU)
busy  out  1  frame in progress
wr_en  out  1  DRAM write strobe, one cycle per word
wr_addr  out  AW  DRAM write address
wr_data  out  64  packed pooled pixels; pixel k of word at bits [8k+7:8k]
frame_done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset, synchronous: all outputs 0. State IDLE. Counters, pack register and line buffer valid flags cleared. Reset mid-frame abandons the frame; no partial write is issued.
- Block has no backpressure and is always ready. in_valid in IDLE is ignored. start while busy is ignored.
- States:
  - IDLE -start-> EVEN_ROW; busy=1 from the cycle after start.
  - EVEN_ROW: pixel pairs (col 2i, 2i+1) are reduced to hmax = max(p0,p1) and stored in line_buf[i], i = 0..CONV_W/2-1. After CONV_W beats -> ODD_ROW.
  - ODD_ROW: each pair gives pooled = max(line_buf[i], max(p0,p1)). The pooled pixel goes to byte slot pack_cnt (0..7) of the pack register. After CONV_W beats -> EVEN_ROW, or -> FLUSH if this was row CONV_H-1.
  - FLUSH: lasts one cycle, then -> IDLE with busy=0.
- Write timing:
  - When the beat completing the 8th pooled pixel is accepted in cycle t, the write is registered: wr_en=1 in cycle t+1, with wr_data = the full word and wr_addr = current pointer.
  - The pointer increments by 1 after each write and wraps modulo 2^AW. pack_cnt returns to 0.
- End of frame (FLUSH):
  - If pack_cnt > 0, one final write is issued with unused upper bytes = 0x00.
  - If the last pooled pixel exactly filled a word, that word's write is the final write and no extra write occurs.
  - frame_done=1 in the same cycle as the final write. If there is no pending data, frame_done is still asserted in the FLUSH cycle.
- Pooled pixels per frame = (CONV_W/2)*(CONV_H/2). Words per frame = ceil(that/8). Defaults: 196 pixels, 25 words, last word holds 4 pixels.
- Pooling does not restart a word per row; pooled pixels pack continuously across rows.
- Gaps (in_valid=0) between beats are allowed anywhere; state holds. wr_en is never asserted for more than 1 consecutive cycle per word.
- The pointer is not reloaded between frames unless start samples a new base_addr. Next frame start is legal the cycle after frame_done.

Test Plan:
- Ramp frame, CONV_W=4, CONV_H=2. base_addr=5. Row0 = 1,9,3,2; row1 = 4,0,7,8. -> Pooled 9,8 (max(1,9,4,0)=9, max(3,2,7,8)=8). Single flush write at addr 5, wr_data=0x0000_0000_0000_0809, with frame_done in the same cycle.
- Default 28x28, every pixel = row*28+col mod 256. -> 25 writes at addrs base..base+24. Word 0 byte k = value of pixel (1, 2k+1). Word 24 upper 4 bytes = 0. frame_done once.
- Exact fill, CONV_W=16, CONV_H=2, all pixels 0xAA. -> Exactly one write, wr_data=0xAAAA_AAAA_AAAA_AAAA. No extra flush write. frame_done coincides with it.
- Random in_valid gaps (~40% idle) on the default frame. -> Data and addresses identical to the gap-free run. wr_en appears only 1 cycle after a completing beat.
- Address wrap: base_addr=1020, default frame. -> Writes at 1020..1023 then 0..20.
- rst asserted mid ODD_ROW with pack_cnt=5. -> Next cycle all outputs 0, busy=0, no write. A fresh start at base 0 then produces the correct full frame.
